// File: rtl/input_port_buffer.sv
// Per-port NoC input stage: flit FIFO, XY route computation, route reservation and forwarding.
// Optional saturating count of dropped malformed flits, enabled by INPUT_PORT_DROP_COUNT_EN.
module input_port_buffer #(
    parameter int N          = 5,
    parameter int DATA_WIDTH = 8,
    parameter int COORD_W    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int X_POS      = 0,
    parameter int Y_POS      = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    req_valid,
    output logic [$clog2(N)-1:0]    req_dir,
    input  logic                    req_grant,
    output logic                    route_rel,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              drop_count
);

    localparam int DIR_W = $clog2(N);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [DIR_W-1:0] DirNorth = DIR_W'(0);
    localparam logic [DIR_W-1:0] DirSouth = DIR_W'(1);
    localparam logic [DIR_W-1:0] DirWest  = DIR_W'(2);
    localparam logic [DIR_W-1:0] DirEast  = DIR_W'(3);
    localparam logic [DIR_W-1:0] DirLocal = DIR_W'(4);

    localparam logic [COORD_W-1:0] XPos = COORD_W'(X_POS);
    localparam logic [COORD_W-1:0] YPos = COORD_W'(Y_POS);

    typedef enum logic [2:0] {
        StIdle,
        StRoute,
        StRequest,
        StForward,
        StRelease
    } stateT;

    stateT state, stateNext;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wrPtr, rdPtr;
    logic                  full, empty, push, pop;
    logic [DATA_WIDTH-1:0] headFlit;
    logic                  headIsHead, headIsTail;

    logic [COORD_W-1:0]    destX, destY;
    logic [DIR_W-1:0]      xyDir, routeDir;
    logic                  routeLoad;
    logic                  fwdValid;

    // ------------------------------------------------------------------ FIFO
    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    assign headFlit   = mem[rdPtr[AW-1:0]];
    assign headIsHead = headFlit[DATA_WIDTH-2];
    assign headIsTail = headFlit[DATA_WIDTH-1];

    // ------------------------------------------------------------------ XY route
    assign destX = headFlit[COORD_W-1:0];
    assign destY = headFlit[2*COORD_W-1:COORD_W];

    always_comb begin
        if (destX > XPos) begin
            xyDir = DirEast;
        end else if (destX < XPos) begin
            xyDir = DirWest;
        end else if (destY > YPos) begin
            xyDir = DirNorth;
        end else if (destY < YPos) begin
            xyDir = DirSouth;
        end else begin
            xyDir = DirLocal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            routeDir <= '0;
        end else if (routeLoad) begin
            routeDir <= xyDir;
        end
    end

    assign req_dir = routeDir;

    // ------------------------------------------------------------------ control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        routeLoad = 1'b0;
        req_valid = 1'b0;
        fwdValid  = 1'b0;
        route_rel = 1'b0;
        unique case (state)
            StIdle: begin
                if (!empty) begin
                    if (headIsHead) begin
                        routeLoad = 1'b1;
                        stateNext = StRoute;
                    end else begin
                        // Stray body/tail with no open route: discard it.
                        pop = 1'b1;
                    end
                end
            end
            StRoute: begin
                stateNext = StRequest;
            end
            StRequest: begin
                req_valid = 1'b1;
                if (req_grant) begin
                    stateNext = StForward;
                end
            end
            StForward: begin
                fwdValid = !empty;
                if (fwdValid && out_ready) begin
                    pop = 1'b1;
                    if (headIsTail) begin
                        stateNext = StRelease;
                    end
                end
            end
            StRelease: begin
                route_rel = 1'b1;
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    assign out_valid = fwdValid;
    assign out_data  = fwdValid ? headFlit : '0;

    // ------------------------------------------------------------------ drop counter
`ifdef INPUT_PORT_DROP_COUNT_EN
    logic       dropEvent;
    logic [7:0] dropCnt;

    assign dropEvent = (state == StIdle) && !empty && !headIsHead;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropCnt <= 8'd0;
        end else if (dropEvent && (dropCnt != 8'hFF)) begin
            dropCnt <= dropCnt + 8'd1;
        end
    end

    assign drop_count = dropCnt;
`else
    assign drop_count = 8'd0;
`endif

endmodule
